// File: rtl/rca_seq_ctrl_if.sv
// Request/result bundle between a datapath and the nibble-serial add/sub controller.
// The requester drives the operands and start; the controller returns status and result.
interface rca_seq_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// WIDTH-bit add/subtract sequenced over one shared 4-bit ripple-carry adder,
// one nibble per cycle, LSB first, with the carry registered between cycles.
module rca_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  rca_seq_ctrl_if.slave       bus
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] acc_d;

  // The shared 4-bit ripple-carry adder plus merge of its nibble into the partial result.
  always_comb begin
    logic c;
    nib_a   = a_q[4*idx_q +: 4];
    nib_b   = b_q[4*idx_q +: 4];
    nib_sum = '0;
    c       = carry_q;
    for (int k = 0; k < 4; k++) begin
      nib_sum[k] = nib_a[k] ^ nib_b[k] ^ c;
      c          = (nib_a[k] & nib_b[k]) | (c & (nib_a[k] ^ nib_b[k]));
    end
    nib_cout = c;
    acc_d    = acc_q;
    acc_d[4*idx_q +: 4] = nib_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            // Subtract is A + ~B + 1, so the incoming carry is forced high.
            carry_q <= bus.sub | bus.cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAdd;
          end else begin
            state_q <= StIdle;
          end
        end
        StAdd: begin
          acc_q   <= acc_d;
          carry_q <= nib_cout;
          if (idx_q == LastIdx) begin
            sum_q   <= acc_d;
            cout_q  <= nib_cout;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl at WIDTH=16: arithmetic corners, handshake
// timing, start-while-busy, back-to-back operations and reset mid-operation.
module tb_rca_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rca_seq_ctrl_if #(.WIDTH(16)) bus ();

  rca_seq_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Steps until done, checking busy on the way; returns the number of edges taken.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      step();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] es, input logic ec,
                              input logic eo);
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " busy@done"}, 32'(bus.busy), 32'd0);
    chk({tag, " sum"}, 32'(bus.sum), 32'(es));
    chk({tag, " cout"}, 32'(bus.cout), 32'(ec));
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic [15:0] es,
                       input logic ec, input logic eo);
    int n;
    launch(a, b, cin, sub);
    wait_done(tag, n);
    chk({tag, " latency"}, 32'(n), 32'd4);
    check_result(tag, es, ec, eo);
    step();
    chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset sum", 32'(bus.sum), 32'd0);
    chk("reset cout", 32'(bus.cout), 32'd0);
    chk("reset ovf", 32'(bus.ovf), 32'd0);

    do_op("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("cin",      16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("ovf add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Idle with changing inputs: outputs must hold.
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    bus.sub = 1'b0;
    repeat (3) step();
    chk("hold sum", 32'(bus.sum), 32'h0000FFFE);
    chk("hold cout", 32'(bus.cout), 32'd0);
    chk("hold busy", 32'(bus.busy), 32'd0);

    // start mid-ADD with different operands is ignored.
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.cin = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("midstart", n);
    chk("midstart latency", 32'(n), 32'd2);
    check_result("midstart", 16'h5555, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    chk("midstart extra done", 32'(pulses), 32'd0);
    chk("midstart idle busy", 32'(bus.busy), 32'd0);

    // Back-to-back: start held on the DONE cycle.
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done("b2b first", n);
    chk("b2b first latency", 32'(n), 32'd4);
    check_result("b2b first", 16'h8000, 1'b0, 1'b1);
    launch(16'h0001, 16'h0002, 1'b0, 1'b0);
    chk("b2b accepted busy", 32'(bus.busy), 32'd1);
    chk("b2b sum stable", 32'(bus.sum), 32'h00008000);
    wait_done("b2b second", n);
    chk("b2b second latency", 32'(n), 32'd4);
    check_result("b2b second", 16'h0003, 1'b0, 1'b0);
    step();

    // Reset sampled at edge T+2 of an operation.
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst sum", 32'(bus.sum), 32'd0);
    chk("rst cout", 32'(bus.cout), 32'd0);
    chk("rst ovf", 32'(bus.ovf), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    chk("rst no done", 32'(pulses), 32'd0);
    do_op("post rst", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
